// File: rtl/mxu_seq_ctrl_if.sv
// Job-control and buffer/PE-array strobe bundle of the MXU sequencer.
// start is a request, not a valid/ready pair. It is honoured only while busy=0,
// and the sequencer drops requests that arrive while a job is running rather than
// queueing them. reload_w and num_vec are qualified by start and must stay stable
// for the whole job. busy and done are registered and answer a start no earlier
// than the cycle after the start edge.
interface mxu_seq_ctrl_if #(
  parameter int ARRAY_N     = 8,
  parameter int TILE_LEN_BW = 8,
  parameter int WADDR_BW    = 3
);
  logic                   start;
  logic                   reload_w;
  logic [TILE_LEN_BW-1:0] num_vec;
  logic                   busy;
  logic                   done;
  logic                   wbuf_rd_en;
  logic [WADDR_BW-1:0]    wbuf_rd_addr;
  logic [ARRAY_N-1:0]     we_rl;
  logic                   abuf_rd_en;
  logic [TILE_LEN_BW-1:0] abuf_rd_addr;
  logic [ARRAY_N-1:0]     din_valid;
  logic [ARRAY_N-1:0]     out_valid;

  modport master (
    output start, reload_w, num_vec,
    input  busy, done, wbuf_rd_en, wbuf_rd_addr, we_rl,
           abuf_rd_en, abuf_rd_addr, din_valid, out_valid
  );

  modport slave (
    input  start, reload_w, num_vec,
    output busy, done, wbuf_rd_en, wbuf_rd_addr, we_rl,
           abuf_rd_en, abuf_rd_addr, din_valid, out_valid
  );
endinterface

// File: rtl/mxu_seq_ctrl.sv
// Sequencer for the NxN weight-stationary MXU: optional weight reload, skewed
// activation streaming, then PSUM pipeline drain. All outputs are registered.
module mxu_seq_ctrl #(
  parameter int ARRAY_N     = 8,
  parameter int TILE_LEN_BW = 8,
  parameter int WADDR_BW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mxu_seq_ctrl_if.slave  bus,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [WADDR_BW-1:0] LAST_ROW   = WADDR_BW'(ARRAY_N - 1);
  localparam logic [WADDR_BW:0]   DRAIN_LAST = (WADDR_BW + 1)'(2 * ARRAY_N - 1);

  state_t                 state_q, state_d;
  logic [TILE_LEN_BW-1:0] num_vec_q, num_vec_d;
  logic                   wen_q, wen_d;
  logic [WADDR_BW-1:0]    waddr_q, waddr_d;
  logic [ARRAY_N-1:0]     we_rl_q, we_rl_d;
  logic                   aen_q, aen_d;
  logic [TILE_LEN_BW-1:0] aaddr_q, aaddr_d;
  logic [ARRAY_N-1:0]     din_q, din_d;
  logic [ARRAY_N-1:0]     ov_q, ov_d;
  logic [WADDR_BW:0]      drain_q, drain_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d   = state_q;
    num_vec_d = num_vec_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    aen_d     = 1'b0;
    aaddr_d   = aaddr_q;
    drain_d   = drain_q;
    // Row reload enable trails the weight read by one cycle (buffer read latency).
    we_rl_d   = wen_q ? (ARRAY_N'(1) << waddr_q) : '0;
    // Lane skew: input lane r lags the read by 1+r, output lane j lags by 1+j+N.
    din_d     = {din_q[ARRAY_N-2:0], aen_q};
    ov_d      = {ov_q[ARRAY_N-2:0], din_q[ARRAY_N-1]};

    // reload_w only steers the transition out of IDLE, so it needs no storage.
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          num_vec_d = bus.num_vec;
          if (bus.reload_w) begin
            state_d = S_LOAD_W;
            wen_d   = 1'b1;
            waddr_d = '0;
          end else if (bus.num_vec == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COMPUTE;
            aen_d   = 1'b1;
            aaddr_d = '0;
          end
        end
      end
      S_LOAD_W: begin
        if (waddr_q == LAST_ROW) begin
          if (num_vec_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_COMPUTE;
            aen_d   = 1'b1;
            aaddr_d = '0;
          end
        end else begin
          wen_d   = 1'b1;
          waddr_d = waddr_q + WADDR_BW'(1);
        end
      end
      S_COMPUTE: begin
        // Stop on the last index instead of a wrap test so num_vec=max cannot roll over.
        if (aaddr_q == num_vec_q - TILE_LEN_BW'(1)) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          aen_d   = 1'b1;
          aaddr_d = aaddr_q + TILE_LEN_BW'(1);
        end
      end
      S_DRAIN: begin
        // 2N cycles cover the deepest lane skew plus the cycle after the last PSUM.
        if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + (WADDR_BW + 1)'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_vec_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      we_rl_q   <= '0;
      aen_q     <= 1'b0;
      aaddr_q   <= '0;
      din_q     <= '0;
      ov_q      <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_vec_q <= num_vec_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      we_rl_q   <= we_rl_d;
      aen_q     <= aen_d;
      aaddr_q   <= aaddr_d;
      din_q     <= din_d;
      ov_q      <= ov_d;
      drain_q   <= drain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.wbuf_rd_en   = wen_q;
  assign bus.wbuf_rd_addr = waddr_q;
  assign bus.we_rl        = we_rl_q;
  assign bus.abuf_rd_en   = aen_q;
  assign bus.abuf_rd_addr = aaddr_q;
  assign bus.din_valid    = din_q;
  assign bus.out_valid    = ov_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mxu_seq_ctrl.sv
// Bench for mxu_seq_ctrl: table of jobs with expected done timing, per-cycle
// output comparison against closed-form timing, and address scoreboards.
module tb_mxu_seq_ctrl;
  localparam int N   = 8;
  localparam int TLB = 8;
  localparam int WB  = 3;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  always #5 clk = ~clk;

  mxu_seq_ctrl_if #(.ARRAY_N(N), .TILE_LEN_BW(TLB), .WADDR_BW(WB)) bus ();

  mxu_seq_ctrl #(.ARRAY_N(N), .TILE_LEN_BW(TLB), .WADDR_BW(WB)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // scoreboard queues: expected read addresses in issue order
  logic [TLB-1:0] exp_q[$];
  logic [WB-1:0]  exp_w_q[$];

  typedef struct {
    bit reload;
    int nv;
    int done_rel;
    bit hold;
    int tail;
  } vec_t;

  vec_t tbl[8];

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {busy, done, wbuf_rd_en, we_rl, abuf_rd_en, din_valid, out_valid} at cycle rel (S = 1)
  function automatic logic [27:0] exp_vec(bit reload, int nv, int done_rel, int rel);
    logic [7:0] we, din, ov;
    logic busy, done, wen, aen;
    int c, v;
    c    = reload ? 1 + N : 1;
    busy = (rel >= 1) && (rel <= done_rel);
    done = (rel == done_rel);
    wen  = reload && (rel >= 1) && (rel <= N);
    we   = '0;
    if (reload && rel >= 2 && rel <= N + 1) we[rel-2] = 1'b1;
    aen  = (rel >= c) && (rel < c + nv);
    for (int r = 0; r < N; r++) begin
      v      = rel - c - 1 - r;
      din[r] = (v >= 0) && (v < nv);
      v      = rel - c - 1 - r - N;
      ov[r]  = (v >= 0) && (v < nv);
    end
    return {busy, done, wen, we, aen, din, ov};
  endfunction

  function automatic int done_of(bit reload, int nv);
    int c;
    c = reload ? 1 + N : 1;
    if (nv == 0) return reload ? 1 + N : 1;
    return c + nv + 2 * N;
  endfunction

  function automatic logic [27:0] act_vec();
    return {bus.busy, bus.done, bus.wbuf_rd_en, bus.we_rl, bus.abuf_rd_en,
            bus.din_valid, bus.out_valid};
  endfunction

  // driver: one job, checked every cycle from the start cycle to done_rel+tail
  task automatic run_job(input bit reload, input int nv, input int done_rel,
                         input bit hold, input int tail, input string tag);
    int ov_cnt[N];
    logic [TLB-1:0] ea;
    logic [WB-1:0]  ew;
    for (int j = 0; j < N; j++) ov_cnt[j] = 0;
    @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.reload_w = reload;
    bus.num_vec  = TLB'(nv);
    if (reload) for (int k = 0; k < N; k++) exp_w_q.push_back(WB'(k));
    for (int v = 0; v < nv; v++) exp_q.push_back(TLB'(v));
    @(negedge clk);
    check_val($sformatf("%s idle_at_start", tag), {4'd0, act_vec()}, {4'd0, exp_vec(reload, nv, done_rel, 0)});
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    for (int rel = 1; rel <= done_rel + tail; rel++) begin
      @(negedge clk);
      check_val($sformatf("%s outputs rel=%0d", tag, rel), {4'd0, act_vec()},
                {4'd0, exp_vec(reload, nv, done_rel, rel)});
      if (bus.wbuf_rd_en) begin
        if (exp_w_q.size() == 0) begin
          check_val($sformatf("%s unexpected_wbuf rel=%0d", tag, rel), 32'd1, 32'd0);
        end else begin
          ew = exp_w_q.pop_front();
          check_val($sformatf("%s wbuf_addr rel=%0d", tag, rel), {29'd0, bus.wbuf_rd_addr}, {29'd0, ew});
        end
      end
      if (bus.abuf_rd_en) begin
        if (exp_q.size() == 0) begin
          check_val($sformatf("%s unexpected_abuf rel=%0d", tag, rel), 32'd1, 32'd0);
        end else begin
          ea = exp_q.pop_front();
          check_val($sformatf("%s abuf_addr rel=%0d", tag, rel), {24'd0, bus.abuf_rd_addr}, {24'd0, ea});
        end
      end
      for (int j = 0; j < N; j++) if (bus.out_valid[j]) ov_cnt[j]++;
    end
    check_val($sformatf("%s abuf_left", tag), 32'(exp_q.size()), 32'd0);
    check_val($sformatf("%s wbuf_left", tag), 32'(exp_w_q.size()), 32'd0);
    exp_q.delete();
    exp_w_q.delete();
    for (int j = 0; j < N; j++)
      check_val($sformatf("%s out_valid_count lane%0d", tag, j), 32'(ov_cnt[j]), 32'(nv));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit r;
    int nv;
    tbl[0] = '{1'b1, 4,   29,  1'b0, 2};
    tbl[1] = '{1'b0, 1,   18,  1'b0, 2};
    tbl[2] = '{1'b1, 0,   9,   1'b0, 2};
    tbl[3] = '{1'b0, 0,   1,   1'b0, 2};
    tbl[4] = '{1'b1, 1,   26,  1'b0, 2};
    tbl[5] = '{1'b0, 3,   20,  1'b1, 0};
    tbl[6] = '{1'b0, 2,   19,  1'b0, 2};
    tbl[7] = '{1'b0, 255, 272, 1'b0, 2};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.reload_w = 1'b0;
    bus.num_vec  = '0;
    repeat (2) @(negedge clk);
    check_val("reset outputs", {4'd0, act_vec()}, 32'd0);
    check_val("reset state", {29'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // reset in the middle of COMPUTE aborts with no done pulse
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.num_vec = TLB'(20);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check_val("abort pre_reset rel=4", {4'd0, act_vec()}, {4'd0, exp_vec(1'b0, 20, done_of(1'b0, 20), 4)});
    #2;
    rst = 1'b1;
    #1;
    check_val("abort async_clear", {4'd0, act_vec()}, 32'd0);
    check_val("abort state", {29'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val($sformatf("abort quiet cyc=%0d", i), {30'd0, bus.busy, bus.done}, 32'd0);
    end

    for (int i = 0; i < 8; i++)
      run_job(tbl[i].reload, tbl[i].nv, tbl[i].done_rel, tbl[i].hold, tbl[i].tail,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      r  = 1'($urandom_range(0, 1));
      nv = $urandom_range(0, 40);
      run_job(r, nv, done_of(r, nv), 1'b0, 2, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
